// File: rtl/cn_sched_pkg.sv
// Shared types and widths for the CryptoNight job scheduler.
// Holds the FSM state enum and the state/nonce/tag/hash-word constants.
package cn_sched_pkg;
  localparam int STATE_W       = 1600;
  localparam int NONCE_W       = 32;
  localparam int TAG_W         = 8;
  localparam int HASH_WORD_LSB = 192;
  localparam int HASH_W        = 64;
  localparam int COUNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;
endpackage

// File: rtl/cn_slot_table.sv
// In-flight slot table: valid bitmap, per-slot nonce storage and a
// lowest-free-slot priority encoder.
// Ports: i_set/i_set_idx/i_set_nonce mark a slot busy, i_clr/i_clr_idx
// free one, i_excl masks slots out of the free search, i_rd_idx reads a
// stored nonce, o_valid/o_free_idx/o_free/o_full report occupancy.
module cn_slot_table
  import cn_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_set,
  input  logic [IW-1:0]      i_set_idx,
  input  logic [NONCE_W-1:0] i_set_nonce,
  input  logic               i_clr,
  input  logic [IW-1:0]      i_clr_idx,
  input  logic [DEPTH-1:0]   i_excl,
  input  logic [IW-1:0]      i_rd_idx,
  output logic [DEPTH-1:0]   o_valid,
  output logic [NONCE_W-1:0] o_rd_nonce,
  output logic [IW-1:0]      o_free_idx,
  output logic               o_free,
  output logic               o_full
);
  logic [DEPTH-1:0]   r_valid;
  logic [NONCE_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]   w_avail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (i_set) r_valid[i_set_idx] <= 1'b1;
      if (i_clr) r_valid[i_clr_idx] <= 1'b0;
    end
  end

  // Nonce storage needs no reset: only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (i_set) r_mem[i_set_idx] <= i_set_nonce;
  end

  assign w_avail = ~r_valid & ~i_excl;

  // Scan high to low so the lowest free index wins.
  always_comb begin
    o_free_idx = '0;
    o_free     = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_avail[i]) begin
        o_free_idx = IW'(i);
        o_free     = 1'b1;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_rd_nonce = r_mem[i_rd_idx];
  assign o_full     = &r_valid;
endmodule

// File: rtl/cn_job_scheduler.sv
// Splits a mining job into per-nonce issues to a hash core, tracks
// outstanding tags and captures results below the difficulty target.
// Ports: job_* (job offer), core_* (issue/return), hit_* (one-entry hit
// buffer), abort, busy, job_done, sticky err_tag and hit_ovf.
module cn_job_scheduler
  import cn_sched_pkg::*;
#(
  parameter int MAX_INFLIGHT = 16,
  parameter int NONCE_LSB    = 312
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [STATE_W-1:0] job_state,
  input  logic [NONCE_W-1:0] job_nonce_start,
  input  logic [COUNT_W-1:0] job_count,
  input  logic [HASH_W-1:0]  job_target,
  input  logic               abort,
  output logic               core_i_valid,
  input  logic               core_o_ready,
  output logic [STATE_W-1:0] core_i_state,
  output logic [TAG_W-1:0]   core_i_nonce,
  input  logic               core_o_done,
  input  logic [TAG_W-1:0]   core_o_nonce,
  input  logic [STATE_W-1:0] core_o_data,
  output logic               hit_valid,
  input  logic               hit_ready,
  output logic [NONCE_W-1:0] hit_nonce,
  output logic [HASH_W-1:0]  hit_hash,
  output logic               busy,
  output logic               job_done,
  output logic               err_tag,
  output logic               hit_ovf
);
  localparam int IW = $clog2(MAX_INFLIGHT);
  localparam int CW = IW + 1;

  sched_state_t r_st, w_st_nxt;

  logic [STATE_W-1:0] r_job_state, r_state;
  logic [NONCE_W-1:0] r_next_nonce, r_nonce;
  logic [COUNT_W-1:0] r_remaining;
  logic [HASH_W-1:0]  r_target;
  logic [CW-1:0]      r_inflight;
  logic               r_valid;
  logic [IW-1:0]      r_tag;
  logic               r_aborted;
  logic               r_hit_valid;
  logic [NONCE_W-1:0] r_hit_nonce;
  logic [HASH_W-1:0]  r_hit_hash;
  logic               r_err, r_ovf;

  logic                    w_accept, w_xfer, w_tag_ok, w_ret, w_bad;
  logic                    w_hit, w_pop, w_load_slot, w_load, w_job_done;
  logic [IW-1:0]           w_ret_idx, w_free_idx;
  logic [MAX_INFLIGHT-1:0] w_valid_map, w_excl;
  logic [NONCE_W-1:0]      w_rd_nonce, w_src_nonce;
  logic [STATE_W-1:0]      w_src_state, w_ins_state;
  logic [COUNT_W-1:0]      w_src_rem;
  logic [HASH_W-1:0]       w_hash;
  logic [CW-1:0]           w_occ;
  logic                    w_free, w_full, w_unused_bits;

  assign w_accept  = (r_st == ST_IDLE) && job_valid;
  assign w_xfer    = r_valid && core_o_ready;
  assign w_ret_idx = core_o_nonce[IW-1:0];
  assign w_tag_ok  = {1'b0, core_o_nonce} < 9'(MAX_INFLIGHT);
  assign w_ret     = core_o_done && w_tag_ok && w_valid_map[w_ret_idx];
  assign w_bad     = core_o_done && !w_ret;
  assign w_hash    = core_o_data[HASH_WORD_LSB +: HASH_W];
  assign w_hit     = w_ret && !r_aborted && (w_hash < r_target);
  assign w_pop     = r_hit_valid && hit_ready;

  assign w_unused_bits = ^{core_o_data[STATE_W-1:HASH_WORD_LSB+HASH_W],
                           core_o_data[HASH_WORD_LSB-1:0], w_full};

  // The pending issue already owns its tag even before the slot is set.
  always_comb begin
    w_excl = '0;
    if (r_valid) w_excl[r_tag] = 1'b1;
  end

  cn_slot_table #(.DEPTH(MAX_INFLIGHT)) u_slots (
    .clk         (clk),
    .rst         (rst),
    .i_set       (w_xfer),
    .i_set_idx   (r_tag),
    .i_set_nonce (r_nonce),
    .i_clr       (w_ret),
    .i_clr_idx   (w_ret_idx),
    .i_excl      (w_excl),
    .i_rd_idx    (w_ret_idx),
    .o_valid     (w_valid_map),
    .o_rd_nonce  (w_rd_nonce),
    .o_free_idx  (w_free_idx),
    .o_free      (w_free),
    .o_full      (w_full)
  );

  // On acceptance the first issue is built straight from the job inputs
  // so core_i_valid rises in the very next cycle.
  assign w_src_state = w_accept ? job_state       : r_job_state;
  assign w_src_nonce = w_accept ? job_nonce_start : r_next_nonce;
  assign w_src_rem   = w_accept ? job_count       : r_remaining;

  always_comb begin
    w_ins_state = w_src_state;
    w_ins_state[NONCE_LSB +: NONCE_W] = w_src_nonce;
  end

  // Occupancy counts a transfer happening now; returns free capacity
  // only from the next cycle on.
  assign w_occ = r_inflight + CW'(w_xfer);

  assign w_load_slot = w_accept ||
                       ((r_st == ST_ISSUE) && !abort &&
                        (!r_valid || w_xfer));
  assign w_load = w_load_slot && (w_src_rem != '0) &&
                  (w_occ < CW'(MAX_INFLIGHT)) && w_free;

  always_comb begin
    w_st_nxt   = r_st;
    w_job_done = 1'b0;
    unique case (r_st)
      ST_IDLE:  if (job_valid) w_st_nxt = ST_ISSUE;
      ST_ISSUE: if (abort || r_remaining == '0) w_st_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (r_inflight == '0 && !r_valid) begin
          w_st_nxt   = ST_IDLE;
          w_job_done = 1'b1;
        end
      end
      default:  w_st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_st <= ST_IDLE;
    else     r_st <= w_st_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_job_state  <= '0;
      r_target     <= '0;
      r_remaining  <= '0;
      r_next_nonce <= '0;
    end else begin
      if (w_accept) begin
        r_job_state <= job_state;
        r_target    <= job_target;
      end
      if (w_load) begin
        r_remaining  <= w_src_rem - COUNT_W'(1);
        r_next_nonce <= w_src_nonce + NONCE_W'(1);
      end else if (w_accept) begin
        r_remaining  <= job_count;
        r_next_nonce <= job_nonce_start;
      end
    end
  end

  // Abort withdraws an issue the core has not yet taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_nonce <= '0;
      r_state <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_tag   <= w_free_idx;
      r_nonce <= w_src_nonce;
      r_state <= w_ins_state;
    end else if (w_xfer || (r_st == ST_ISSUE && abort)) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_inflight <= '0;
    else     r_inflight <= r_inflight + CW'(w_xfer) - CW'(w_ret);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_aborted <= 1'b0;
    else if (w_accept)                    r_aborted <= 1'b0;
    else if (abort && r_st != ST_IDLE)    r_aborted <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_valid <= 1'b0;
      r_hit_nonce <= '0;
      r_hit_hash  <= '0;
    end else if (w_hit && (!r_hit_valid || hit_ready)) begin
      r_hit_valid <= 1'b1;
      r_hit_nonce <= w_rd_nonce;
      r_hit_hash  <= w_hash;
    end else if (w_pop) begin
      r_hit_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_bad) r_err <= 1'b1;
      if (w_hit && r_hit_valid && !hit_ready) r_ovf <= 1'b1;
    end
  end

  assign job_ready    = (r_st == ST_IDLE);
  assign busy         = (r_st != ST_IDLE);
  assign job_done     = w_job_done;
  assign core_i_valid = r_valid;
  assign core_i_state = r_state;
  assign core_i_nonce = TAG_W'(r_tag);
  assign hit_valid    = r_hit_valid;
  assign hit_nonce    = r_hit_nonce;
  assign hit_hash     = r_hit_hash;
  assign err_tag      = r_err;
  assign hit_ovf      = r_ovf;
endmodule

// File: tb/tb_cn_job_scheduler.sv
// Directed bench for cn_job_scheduler with an issue scoreboard.
// Expected issues are queued before each job and checked on transfer.
module tb_cn_job_scheduler;
  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid, job_ready, abort;
  logic [1599:0] job_state;
  logic [31:0]   job_nonce_start;
  logic [15:0]   job_count;
  logic [63:0]   job_target;
  logic          core_i_valid, core_o_ready, core_o_done;
  logic [1599:0] core_i_state, core_o_data;
  logic [7:0]    core_i_nonce, core_o_nonce;
  logic          hit_valid, hit_ready;
  logic [31:0]   hit_nonce;
  logic [63:0]   hit_hash;
  logic          busy, job_done, err_tag, hit_ovf;

  cn_job_scheduler dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_state(job_state), .job_nonce_start(job_nonce_start),
    .job_count(job_count), .job_target(job_target), .abort(abort),
    .core_i_valid(core_i_valid), .core_o_ready(core_o_ready),
    .core_i_state(core_i_state), .core_i_nonce(core_i_nonce),
    .core_o_done(core_o_done), .core_o_nonce(core_o_nonce),
    .core_o_data(core_o_data),
    .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_nonce(hit_nonce), .hit_hash(hit_hash),
    .busy(busy), .job_done(job_done),
    .err_tag(err_tag), .hit_ovf(hit_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] nonce;
    logic [7:0]  tag;
  } iss_t;

  iss_t          exp_q[$];
  iss_t          mon_e;
  logic [1599:0] tmpl, mon_state;
  int            total = 0;
  int            bad = 0;
  int            n_issue = 0;
  int            base;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0b exp=%0b", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && core_i_valid && core_o_ready) begin
      n_issue++;
      if (exp_q.size() == 0) begin
        chk1("iss_unexpected", 1'b1, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("iss_nonce", 64'(core_i_state[312 +: 32]), 64'(mon_e.nonce));
        chk("iss_tag", 64'(core_i_nonce), 64'(mon_e.tag));
        mon_state = tmpl;
        mon_state[312 +: 32] = mon_e.nonce;
        total++;
        assert (core_i_state === mon_state) else begin
          bad++;
          $error("FAIL iss_state obs=%0h exp=%0h",
                 core_i_state[383:256], mon_state[383:256]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] n, input logic [7:0] t);
    exp_q.push_back(iss_t'{nonce: n, tag: t});
  endtask

  task automatic new_tmpl();
    for (int i = 0; i < 50; i++) tmpl[i*32 +: 32] = $urandom();
  endtask

  task automatic start(input logic [31:0] s, input logic [15:0] c,
                       input logic [63:0] tg);
    job_nonce_start = s;
    job_count       = c;
    job_target      = tg;
    job_state       = tmpl;
    job_valid       = 1'b1;
    tick();
    job_valid       = 1'b0;
  endtask

  task automatic ret(input logic [7:0] t, input logic [63:0] h);
    core_o_done         = 1'b1;
    core_o_nonce        = t;
    core_o_data         = '0;
    core_o_data[255:192] = h;
    tick();
    core_o_done         = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      if (job_done) seen = 1'b1;
      else tick();
    end
    chk1(tag, seen, 1'b1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    job_valid = 1'b0; job_state = '0; job_nonce_start = '0;
    job_count = '0; job_target = '0; abort = 1'b0;
    core_o_ready = 1'b0; core_o_done = 1'b0; core_o_nonce = '0;
    core_o_data = '0; hit_ready = 1'b0; tmpl = '0;
    #12;
    chk1("rst_ready", job_ready, 1'b1);
    chk1("rst_valid", core_i_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", job_done, 1'b0);
    chk1("rst_hit", hit_valid, 1'b0);
    chk1("rst_err", err_tag, 1'b0);
    chk1("rst_ovf", hit_ovf, 1'b0);
    chk("rst_hnonce", 64'(hit_nonce), 64'd0);
    chk1("rst_state", core_i_state == '0, 1'b1);
    rst = 1'b0;
    tick();

    // Four back-to-back issues.
    new_tmpl();
    core_o_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i), 8'(i));
    start(32'h10, 16'd4, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk1("s1_valid", core_i_valid, 1'b1);
      tick();
    end
    chk1("s1_valid_end", core_i_valid, 1'b0);
    for (int i = 0; i < 4; i++) ret(8'(i), 64'h0);
    wait_done("s1_done", 4);
    chk1("s1_nohit", hit_valid, 1'b0);
    chk1("s1_err", err_tag, 1'b0);

    // Empty job.
    base = n_issue;
    start(32'h0, 16'd0, 64'd0);
    chk1("s0_valid", core_i_valid, 1'b0);
    chk1("s0_done_early", job_done, 1'b0);
    chk1("s0_busy", busy, 1'b1);
    tick();
    chk1("s0_done", job_done, 1'b1);
    tick();
    chk1("s0_idle", job_ready, 1'b1);
    chk("s0_issues", 64'(n_issue - base), 64'd0);

    // In-flight cap with a silent core.
    new_tmpl();
    base = n_issue;
    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i), 8'(i));
    start(32'h100, 16'd40, '1);
    for (int i = 0; i < 25; i++) tick();
    chk("s2_cap", 64'(n_issue - base), 64'd16);
    chk1("s2_valid_off", core_i_valid, 1'b0);
    push(32'h110, 8'd5);
    ret(8'd5, '1);
    for (int i = 0; i < 5; i++) tick();
    chk("s2_one_more", 64'(n_issue - base), 64'd17);
    chk1("s2_valid_off2", core_i_valid, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 16; i++) ret(8'(i), 64'h0);
    chk1("s2_abort_nohit", hit_valid, 1'b0);
    chk1("s2_done", job_done, 1'b1);
    tick();

    // Out-of-order returns and tag reuse.
    new_tmpl();
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(i), 8'(i));
    push(32'h204, 8'd4);
    push(32'h205, 8'd0);
    push(32'h206, 8'd1);
    push(32'h207, 8'd3);
    start(32'h200, 16'd20, 64'd0);
    for (int i = 0; i < 4; i++) tick();
    core_o_ready = 1'b0;
    ret(8'd3, 64'h0);
    ret(8'd0, 64'h0);
    core_o_ready = 1'b1;
    ret(8'd1, 64'h0);
    for (int i = 0; i < 3; i++) tick();
    core_o_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    core_o_ready = 1'b1;
    ret(8'd0, 64'h0);
    ret(8'd1, 64'h0);
    ret(8'd2, 64'h0);
    ret(8'd3, 64'h0);
    chk1("s3_not_done", job_done, 1'b0);
    ret(8'd4, 64'h0);
    chk1("s3_done", job_done, 1'b1);
    tick();
    chk("s3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Hit compare, hold and overflow.
    new_tmpl();
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(i), 8'(i));
    start(32'h300, 16'd3, 64'h100);
    for (int i = 0; i < 5; i++) tick();
    ret(8'd0, 64'hFF);
    chk1("s4_hit", hit_valid, 1'b1);
    chk("s4_hnonce", 64'(hit_nonce), 64'h300);
    chk("s4_hhash", hit_hash, 64'hFF);
    ret(8'd1, 64'h100);
    chk1("s4_eq_nohit", hit_ovf, 1'b0);
    chk("s4_hold", 64'(hit_nonce), 64'h300);
    ret(8'd2, 64'h5);
    chk1("s4_ovf", hit_ovf, 1'b1);
    chk("s4_hold2", hit_hash, 64'hFF);
    chk1("s4_done", job_done, 1'b1);
    tick();
    chk1("s4_ovf_sticky", hit_ovf, 1'b1);
    hit_ready = 1'b1;
    tick();
    hit_ready = 1'b0;
    chk1("s4_pop", hit_valid, 1'b0);

    // Abort with five in flight, plus a bogus tag.
    new_tmpl();
    base = n_issue;
    for (int i = 0; i < 5; i++) push(32'h400 + 32'(i), 8'(i));
    start(32'h400, 16'd10, '1);
    chk1("s5_ovf_clr", hit_ovf, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    core_o_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    core_o_ready = 1'b1;
    chk1("s5_valid_off", core_i_valid, 1'b0);
    ret(8'd20, 64'h0);
    chk1("s5_err", err_tag, 1'b1);
    for (int i = 0; i < 4; i++) ret(8'(i), 64'h0);
    chk1("s5_not_done", job_done, 1'b0);
    ret(8'd4, 64'h0);
    chk1("s5_done", job_done, 1'b1);
    chk1("s5_nohit", hit_valid, 1'b0);
    chk("s5_issues", 64'(n_issue - base), 64'd5);
    tick();

    // Reset in the middle of a job.
    new_tmpl();
    push(32'h500, 8'd0);
    push(32'h501, 8'd1);
    start(32'h500, 16'd10, 64'd0);
    tick();
    tick();
    core_o_ready = 1'b0;
    ret(8'd9, 64'h0);
    chk1("s6_err", err_tag, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("s6_valid", core_i_valid, 1'b0);
    chk1("s6_busy", busy, 1'b0);
    chk1("s6_ready", job_ready, 1'b1);
    chk1("s6_err_clr", err_tag, 1'b0);
    chk1("s6_state", core_i_state == '0, 1'b1);
    #3;
    rst = 1'b0;
    core_o_ready = 1'b1;
    tick();

    // Nonce wrap, and slots start from tag 0 after reset.
    new_tmpl();
    push(32'hFFFF_FFFE, 8'd0);
    push(32'hFFFF_FFFF, 8'd1);
    push(32'h0, 8'd2);
    start(32'hFFFF_FFFE, 16'd3, 64'd0);
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 3; i++) ret(8'(i), 64'h0);
    wait_done("s7_done", 4);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
